irq_controller: RTL and testbench

Parametrised machine-level interrupt controller for the core's CSR datapath. It synchronises NUM_IRQ external interrupt sources and latches them into a pending vector, with edge or level capture selectable per source. It arbitrates the pending sources by fixed priority and presents a single held request, cause code and trap target PC to the trap unit. It runs a request/acknowledge/mret handshake with the core, so a cause stays stable from request until the trap is taken.

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_controller_prio_enc.sv | 22 ++
 rtl/irq_controller.sv | 150 +++++++++++++++
 tb/tb_irq_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the machine-level interrupt controller.
package irq_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE   = 2'd0,
        IRQ_REQ    = 2'd1,
        IRQ_ACTIVE = 2'd2
    } irq_state_e;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    // Trap target for a cause. Vectored mode adds cause*4 to the aligned base
    // and wraps modulo 2^32. Modes 1x are reserved and fall back to direct.
    function automatic logic [31:0] vec_target(input logic [31:0] mtvec,
                                               input logic [31:0] cause);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (mtvec[1:0] == MTVEC_VECTORED) begin
            return base + (cause << 2);
        end
        return base;
    endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 16,
    parameter int CAUSE_W = 5
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               any_valid,
    output logic [CAUSE_W-1:0] index
);

    // Scan from the top down so the lowest set bit is the last to write index.
    always_comb begin
        any_valid = |req;
        index     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Machine-level interrupt controller: synchronises sources, latches pending
// bits (edge or level per source), picks the highest-priority eligible source
// and runs the request / acknowledge / mret handshake with the core.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IRQ_IDLE   | no request outstanding; waiting for an eligible source
// IRQ_REQ    | irq_req high, cause and target held until ack or withdrawal
// IRQ_ACTIVE | trap taken, handler running; no nesting until mret
module irq_controller
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = 16,
    parameter int CAUSE_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_edge,
    input  logic [NUM_IRQ-1:0] mie_en,
    input  logic               mstatus_mie,
    input  logic [31:0]        mtvec,
    input  logic               trap_ack,
    input  logic               mret,
    output logic [NUM_IRQ-1:0] mip,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [31:0]        trap_pc
);

    logic [NUM_IRQ-1:0] s1_q, s1_d;
    logic [NUM_IRQ-1:0] s2_q, s2_d;
    logic [NUM_IRQ-1:0] s2_prev_q, s2_prev_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;

    logic [NUM_IRQ-1:0] elig;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] rise;
    logic               elig_sel;
    logic               win_valid;
    logic [CAUSE_W-1:0] win_idx;

    irq_state_e         state_q;
    logic               irq_req_q;
    logic [CAUSE_W-1:0] irq_cause_q;
    logic [31:0]        trap_pc_q;

    logic               ack_accept;

    assign elig       = pend_q & mie_en;
    assign ack_accept = (state_q == IRQ_REQ) && trap_ack;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .CAUSE_W (CAUSE_W)
    ) u_prio_enc (
        .req       (elig),
        .any_valid (win_valid),
        .index     (win_idx)
    );

    // Decode the latched cause into a clear mask and an eligibility bit
    // without indexing the vector by a possibly wider cause field.
    always_comb begin
        clr      = '0;
        elig_sel = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (CAUSE_W'(i) == irq_cause_q) begin
                clr[i]   = ack_accept;
                elig_sel = elig[i];
            end
        end
    end

    // Synchroniser chain and pending update; in edge mode a new rise beats a
    // same-cycle clear so the second event is not lost.
    always_comb begin
        s1_d      = irq_src;
        s2_d      = s1_q;
        s2_prev_d = s2_q;
        rise      = s2_q & ~s2_prev_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_edge[i]) begin
                pend_d[i] = (pend_q[i] & ~clr[i]) | rise[i];
            end else begin
                pend_d[i] = s2_q[i];
            end
        end
    end

    // Synchroniser and pending registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s2_prev_q <= '0;
            pend_q    <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s2_prev_q <= s2_prev_d;
            pend_q    <= pend_d;
        end
    end

    // Handshake FSM with registered request, cause and target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IRQ_IDLE;
            irq_req_q   <= 1'b0;
            irq_cause_q <= '0;
            trap_pc_q   <= '0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (mstatus_mie && win_valid) begin
                        state_q     <= IRQ_REQ;
                        irq_req_q   <= 1'b1;
                        irq_cause_q <= win_idx;
                        trap_pc_q   <= vec_target(mtvec, 32'(win_idx));
                    end
                end
                IRQ_REQ: begin
                    if (trap_ack) begin
                        state_q   <= IRQ_ACTIVE;
                        irq_req_q <= 1'b0;
                    end else if (!elig_sel || !mstatus_mie) begin
                        state_q   <= IRQ_IDLE;
                        irq_req_q <= 1'b0;
                    end
                end
                IRQ_ACTIVE: begin
                    if (mret) begin
                        state_q <= IRQ_IDLE;
                    end
                end
                default: begin
                    state_q   <= IRQ_IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mip       = pend_q;
    assign irq_req   = irq_req_q;
    assign irq_cause = irq_cause_q;
    assign trap_pc   = trap_pc_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller.
module tb_irq_controller;

    localparam int NUM_IRQ = 16;
    localparam int CAUSE_W = 5;

    logic               clk;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] mie_en;
    logic               mstatus_mie;
    logic [31:0]        mtvec;
    logic               trap_ack;
    logic               mret;
    logic [NUM_IRQ-1:0] mip;
    logic               irq_req;
    logic [CAUSE_W-1:0] irq_cause;
    logic [31:0]        trap_pc;

    int checks = 0;
    int errors = 0;

    irq_controller #(
        .NUM_IRQ (NUM_IRQ),
        .CAUSE_W (CAUSE_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_src     (irq_src),
        .irq_edge    (irq_edge),
        .mie_en      (mie_en),
        .mstatus_mie (mstatus_mie),
        .mtvec       (mtvec),
        .trap_ack    (trap_ack),
        .mret        (mret),
        .mip         (mip),
        .irq_req     (irq_req),
        .irq_cause   (irq_cause),
        .trap_pc     (trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
    endtask

    task automatic pulse_mret();
        mret = 1'b1;
        tick();
        mret = 1'b0;
    endtask

    task automatic settle();
        irq_src  = '0;
        trap_ack = 1'b0;
        tick(4);
        pulse_mret();
        tick(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        irq_src = '0; irq_edge = '0; mie_en = '1; mstatus_mie = 1'b1;
        mtvec = 32'h0000_1000; trap_ack = 1'b0; mret = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", irq_req); end
        checks++; if (mip !== 16'h0000) begin errors++; $display("FAIL rst_mip got %h exp 0000", mip); end
        checks++; if (irq_cause !== 5'd0) begin errors++; $display("FAIL rst_cause got %0d exp 0", irq_cause); end
        checks++; if (trap_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", trap_pc); end
    endtask

    task automatic test_level_direct();
        irq_edge = '0; mtvec = 32'h0000_1000;
        irq_src[3] = 1'b1;
        tick(3);
        checks++; if (mip !== 16'h0008) begin errors++; $display("FAIL lvl_mip got %h exp 0008", mip); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL lvl_early_req got %0b exp 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL lvl_req got %0b exp 1", irq_req); end
        checks++; if (irq_cause !== 5'd3) begin errors++; $display("FAIL lvl_cause got %0d exp 3", irq_cause); end
        checks++; if (trap_pc !== 32'h0000_1000) begin errors++; $display("FAIL lvl_pc got %h exp 00001000", trap_pc); end
        pulse_ack();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL lvl_ack_req got %0b exp 0", irq_req); end
        checks++; if (mip !== 16'h0008) begin errors++; $display("FAIL lvl_noclr got %h exp 0008", mip); end
        settle();
        checks++; if (irq_req !== 1'b0 || mip !== 16'h0) begin errors++; $display("FAIL lvl_settle got req %0b mip %h exp 0 0000", irq_req, mip); end
    endtask

    task automatic test_vectored_edge();
        mtvec = 32'h0000_2001; irq_edge = 16'h0024;
        irq_src[5] = 1'b1; irq_src[2] = 1'b1;
        tick(3);
        checks++; if (mip !== 16'h0024) begin errors++; $display("FAIL vec_mip got %h exp 0024", mip); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL vec_req got %0b exp 1", irq_req); end
        checks++; if (irq_cause !== 5'd2) begin errors++; $display("FAIL vec_cause got %0d exp 2", irq_cause); end
        checks++; if (trap_pc !== 32'h0000_2008) begin errors++; $display("FAIL vec_pc got %h exp 00002008", trap_pc); end
        pulse_ack();
        checks++; if (mip !== 16'h0020) begin errors++; $display("FAIL vec_clr got %h exp 0020", mip); end
        pulse_mret();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL vec_gap got %0b exp 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL vec_req2 got %0b exp 1", irq_req); end
        checks++; if (irq_cause !== 5'd5) begin errors++; $display("FAIL vec_cause2 got %0d exp 5", irq_cause); end
        checks++; if (trap_pc !== 32'h0000_2014) begin errors++; $display("FAIL vec_pc2 got %h exp 00002014", trap_pc); end
        pulse_ack();
        checks++; if (mip !== 16'h0000) begin errors++; $display("FAIL vec_clr2 got %h exp 0000", mip); end
        settle();
        irq_edge = '0;
    endtask

    task automatic test_withdraw_and_no_nesting();
        mtvec = 32'h0000_1000; irq_edge = '0;
        irq_src[7] = 1'b1;
        tick(4);
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd7) begin errors++; $display("FAIL wd_req got %0b/%0d exp 1/7", irq_req, irq_cause); end
        irq_src[7] = 1'b0;
        tick(3);
        checks++; if (irq_req !== 1'b1 || mip !== 16'h0) begin errors++; $display("FAIL wd_hold got req %0b mip %h exp 1 0000", irq_req, mip); end
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL wd_drop got %0b exp 0", irq_req); end
        tick(2);
        irq_src[7] = 1'b1;
        tick(4);
        checks++; if (irq_req !== 1'b1) begin errors++; $display("FAIL wd_req2 got %0b exp 1", irq_req); end
        irq_src[7] = 1'b0;
        tick(3);
        pulse_ack();
        checks++; if (irq_req !== 1'b0 || irq_cause !== 5'd7) begin errors++; $display("FAIL wd_ackwin got %0b/%0d exp 0/7", irq_req, irq_cause); end
        irq_edge[1] = 1'b1;
        irq_src[1] = 1'b1;
        tick(5);
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL nest_req got %0b exp 0", irq_req); end
        checks++; if (mip !== 16'h0002) begin errors++; $display("FAIL nest_mip got %h exp 0002", mip); end
        pulse_mret();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL nest_gap got %0b exp 0", irq_req); end
        tick();
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd1) begin errors++; $display("FAIL nest_req2 got %0b/%0d exp 1/1", irq_req, irq_cause); end
        pulse_ack();
        checks++; if (mip !== 16'h0000) begin errors++; $display("FAIL nest_clr got %h exp 0000", mip); end
        settle();
        irq_edge = '0;
    endtask

    task automatic test_set_wins();
        irq_edge[4] = 1'b1;
        irq_src[4] = 1'b1;
        tick(4);
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd4) begin errors++; $display("FAIL sw_req got %0b/%0d exp 1/4", irq_req, irq_cause); end
        irq_src[4] = 1'b0;
        tick(3);
        irq_src[4] = 1'b1;
        tick(2);
        pulse_ack();
        checks++; if (mip !== 16'h0010) begin errors++; $display("FAIL sw_mip got %h exp 0010", mip); end
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL sw_ack got %0b exp 0", irq_req); end
        pulse_mret();
        tick();
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd4) begin errors++; $display("FAIL sw_req2 got %0b/%0d exp 1/4", irq_req, irq_cause); end
        pulse_ack();
        checks++; if (mip !== 16'h0000) begin errors++; $display("FAIL sw_clr got %h exp 0000", mip); end
        settle();
        irq_edge = '0;
    endtask

    task automatic test_global_enable();
        mstatus_mie = 1'b0; mtvec = 32'h0000_1000;
        irq_src[2] = 1'b1;
        tick(5);
        checks++; if (irq_req !== 1'b0 || mip !== 16'h0004) begin errors++; $display("FAIL ge_off got req %0b mip %h exp 0 0004", irq_req, mip); end
        mstatus_mie = 1'b1;
        tick();
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd2) begin errors++; $display("FAIL ge_on got %0b/%0d exp 1/2", irq_req, irq_cause); end
        mstatus_mie = 1'b0;
        tick();
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL ge_withdraw got %0b exp 0", irq_req); end
        irq_src[2] = 1'b0;
        tick(4);
        mstatus_mie = 1'b1;
        tick(2);
        checks++; if (irq_req !== 1'b0) begin errors++; $display("FAIL ge_idle got %0b exp 0", irq_req); end
    endtask

    task automatic test_mask_and_modes();
        mie_en = 16'hFFFE; mtvec = 32'hFFFF_FFFD;
        irq_src[0] = 1'b1; irq_src[3] = 1'b1;
        tick(4);
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd3) begin errors++; $display("FAIL mask_cause got %0b/%0d exp 1/3", irq_req, irq_cause); end
        checks++; if (trap_pc !== 32'h0000_0008) begin errors++; $display("FAIL wrap_pc got %h exp 00000008", trap_pc); end
        mtvec = 32'h0000_4000;
        tick();
        checks++; if (trap_pc !== 32'h0000_0008) begin errors++; $display("FAIL mtvec_hold got %h exp 00000008", trap_pc); end
        pulse_ack();
        settle();
        mie_en = '1;
        mtvec = 32'h0000_2003;
        irq_src[6] = 1'b1;
        tick(4);
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd6) begin errors++; $display("FAIL rsv_cause got %0b/%0d exp 1/6", irq_req, irq_cause); end
        checks++; if (trap_pc !== 32'h0000_2000) begin errors++; $display("FAIL rsv_pc got %h exp 00002000", trap_pc); end
        pulse_ack();
        settle();
    endtask

    task automatic test_reset_mid();
        irq_edge = '0; mtvec = 32'h0000_1000;
        irq_src[4] = 1'b1; irq_src[5] = 1'b1;
        tick(4);
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd4) begin errors++; $display("FAIL rm_req got %0b/%0d exp 1/4", irq_req, irq_cause); end
        pulse_ack();
        checks++; if (mip !== 16'h0030) begin errors++; $display("FAIL rm_mip got %h exp 0030", mip); end
        reset = 1'b1;
        tick();
        checks++; if (mip !== 16'h0000) begin errors++; $display("FAIL rm_mip0 got %h exp 0000", mip); end
        checks++; if (irq_req !== 1'b0 || trap_pc !== 32'h0) begin errors++; $display("FAIL rm_out got req %0b pc %h exp 0 0", irq_req, trap_pc); end
        reset = 1'b0;
        tick(4);
        checks++; if (irq_req !== 1'b1 || irq_cause !== 5'd4) begin errors++; $display("FAIL rm_idle got %0b/%0d exp 1/4", irq_req, irq_cause); end
        reset = 1'b1;
        tick();
        checks++; if (irq_req !== 1'b0 || irq_cause !== 5'd0) begin errors++; $display("FAIL rm_req_rst got %0b/%0d exp 0/0", irq_req, irq_cause); end
        irq_src = '0;
        tick();
        reset = 1'b0;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_level_direct();
        test_vectored_edge();
        test_withdraw_and_no_nesting();
        test_set_wins();
        test_global_enable();
        test_mask_and_modes();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
